// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
// Contents:
//   WORD_W          - data/address word width
//   STARVE_MAX_DEF  - default number of data grants a waiting fetch may lose in a row
//   STARVE_W        - width of the starvation counter (holds 0..15)
//   arb_state_e     - arbiter FSM state encoding
package mem_port_arbiter_pkg;

    localparam int WORD_W         = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (count -> 0)
//   clr_i - clear to 0 (takes precedence over inc_i)
//   inc_i - increment by one, stopping at MAX
//   cnt_o - current count
module mem_port_arbiter_sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch
// and the data (load/store) stage. One access in flight at a time; data has
// priority, but after STARVE_MAX consecutive data grants against a waiting
// fetch, the fetch is granted next.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   if_req/if_addr/if_cancel          - fetch request, address, discard
//   if_rdata/if_ready                 - fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata         - data request, store flag, address, store data
//   d_rdata/d_ready                   - load word and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata - memory access, held until mem_ack
//   mem_rdata/mem_ack                 - memory read data and completion
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
    logic [WORD_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                cancel_pend_q, cancel_pend_d;
    logic [STARVE_W-1:0] starve_cnt;

    logic i_ok, d_ok, grant_i, grant_d;

    // A requester is ineligible in its own ready cycle: its request line is
    // still high there but already answered.
    assign i_ok    = if_req & ~if_cancel & ~if_ready_q;
    assign d_ok    = d_req & ~d_ready_q;
    assign grant_d = (state_q == IDLE) && d_ok && (!i_ok || (starve_cnt < STARVE_LIM));
    assign grant_i = (state_q == IDLE) && !grant_d && i_ok;

    // Counts data grants that overtook a waiting fetch.
    mem_port_arbiter_sat_counter #(
        .W   (STARVE_W),
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (grant_i),
        .inc_i (grant_d & i_ok),
        .cnt_o (starve_cnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_ready_d    = 1'b0;
        d_ready_d     = 1'b0;
        cancel_pend_d = cancel_pend_q;
        case (state_q)
            IDLE: begin
                // A stray mem_ack here (e.g. after a mid-access reset) is ignored.
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_i) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    cancel_pend_d = 1'b0;
                    // A fetch cancelled at any point of its access is dropped silently.
                    if (!cancel_pend_q && !if_cancel) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end
                end else if (if_cancel) begin
                    cancel_pend_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_rdata_d = mem_rdata;
                    d_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: datapath registers are reset too, since outputs must read as zero after reset, not just the control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_ready_q    <= 1'b0;
            d_ready_q     <= 1'b0;
            cancel_pend_q <= 1'b0;
        end else begin
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            if_ready_q    <= if_ready_d;
            d_ready_q     <= d_ready_d;
            cancel_pend_q <= cancel_pend_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;

endmodule
